// File: rtl/long_op_writeback_pkg.sv
// Shared types and widths for the long-latency writeback path.
package long_op_writeback_pkg;

    localparam int RV32_reg_addr_width_gp = 5;
    localparam int rv32_data_width_gp     = 32;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_REMOTE,
        WB_DIV
    } wb_src_e;

endpackage

// File: rtl/long_op_rsp_fifo.sv
// Small FIFO with a combinational head; pointers carry one extra wrap bit to tell full from empty.
module long_op_rsp_fifo #(
    parameter int width_p = 37,
    parameter int els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i
);

    localparam int addr_w_lp = $clog2(els_p);

    logic [addr_w_lp:0]   wptr_q, wptr_d;
    logic [addr_w_lp:0]   rptr_q, rptr_d;
    logic [width_p-1:0]   mem_q [els_p];
    logic                 empty, full, enq, deq;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[addr_w_lp] != rptr_q[addr_w_lp])
                && (wptr_q[addr_w_lp-1:0] == rptr_q[addr_w_lp-1:0]);

    // Ready is purely ~full, so a full FIFO never enqueues even when popping.
    assign ready_o = ~full;
    assign v_o     = ~empty;
    assign data_o  = mem_q[rptr_q[addr_w_lp-1:0]];

    assign enq = v_i & ~full;
    assign deq = yumi_i & ~empty;

    assign wptr_d = wptr_q + (addr_w_lp+1)'(enq);
    assign rptr_d = rptr_q + (addr_w_lp+1)'(deq);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wptr_q[addr_w_lp-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/long_op_writeback.sv
// Writes buffered remote-load responses and divider results into idle RF write slots and
// clears their scoreboard entries; forces the pipeline to yield after a bounded wait.
module long_op_writeback
    import long_op_writeback_pkg::*;
#(
    parameter int id_width_p     = RV32_reg_addr_width_gp,
    parameter int data_width_p   = rv32_data_width_gp,
    parameter int fifo_els_p     = 2,
    parameter int starve_limit_p = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    rsp_v_i,
    input  logic [id_width_p-1:0]   rsp_id_i,
    input  logic [data_width_p-1:0] rsp_data_i,
    output logic                    rsp_ready_o,
    input  logic                    div_v_i,
    input  logic [id_width_p-1:0]   div_id_i,
    input  logic [data_width_p-1:0] div_data_i,
    output logic                    div_yumi_o,
    input  logic                    pipe_wb_v_i,
    output logic                    stall_pipe_o,
    output logic                    rf_wen_o,
    output logic [id_width_p-1:0]   rf_waddr_o,
    output logic [data_width_p-1:0] rf_wdata_o,
    output logic                    clear_o,
    output logic [id_width_p-1:0]   clear_id_o
);

    localparam int cnt_w_lp = $clog2(starve_limit_p + 1);
    localparam logic [cnt_w_lp-1:0] limit_lp = cnt_w_lp'(starve_limit_p);

    logic                             fifo_v, fifo_yumi;
    logic [id_width_p+data_width_p-1:0] fifo_data;
    wb_src_e                          src;
    logic [id_width_p-1:0]            win_id;
    logic [data_width_p-1:0]          win_data;
    logic                             grant, write, pending;
    logic [cnt_w_lp-1:0]              cnt_q, cnt_d;
    logic                             stall_q;

    long_op_rsp_fifo #(
        .width_p (id_width_p + data_width_p),
        .els_p   (fifo_els_p)
    ) rsp_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .v_i     (rsp_v_i),
        .data_i  ({rsp_id_i, rsp_data_i}),
        .ready_o (rsp_ready_o),
        .v_o     (fifo_v),
        .data_o  (fifo_data),
        .yumi_i  (fifo_yumi)
    );

    always_comb begin
        src      = WB_NONE;
        win_id   = '0;
        win_data = '0;
        if (!pipe_wb_v_i && !reset_i) begin
            if (fifo_v) begin
                src      = WB_REMOTE;
                win_id   = fifo_data[id_width_p+data_width_p-1:data_width_p];
                win_data = fifo_data[data_width_p-1:0];
            end else if (div_v_i) begin
                src      = WB_DIV;
                win_id   = div_id_i;
                win_data = div_data_i;
            end
        end
    end

    assign grant      = (src != WB_NONE);
    // x0 is never scored: its results are drained without touching the RF or scoreboard.
    assign write      = grant && (win_id != '0);
    assign fifo_yumi  = (src == WB_REMOTE);
    assign div_yumi_o = (src == WB_DIV);

    assign rf_wen_o   = write;
    assign rf_waddr_o = write ? win_id : '0;
    assign rf_wdata_o = write ? win_data : '0;
    assign clear_o    = write;
    assign clear_id_o = write ? win_id : '0;

    assign pending = fifo_v | div_v_i;

    always_comb begin
        cnt_d = cnt_q;
        if (grant || !pending) begin
            cnt_d = '0;
        end else if (pipe_wb_v_i && (cnt_q != limit_lp)) begin
            cnt_d = cnt_q + cnt_w_lp'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            stall_q <= (cnt_d == limit_lp);
        end
    end

    assign stall_pipe_o = stall_q;

    no_pipe_wb_while_stalled: assert property (
        @(posedge clk_i) disable iff (reset_i) !(pipe_wb_v_i && stall_q)
    );

endmodule
